// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver.
// FSM states, parity-type encodings and the 3-sample vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Line/host bundle of the UART receiver.
// master drives the line and config, slave is the receiver.
interface uart_rx_oversample_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic                  par_EN;
  logic                  par_TYP;
  logic [DATA_WIDTH-1:0] RXDATA;
  logic                  VALID_RX;
  logic                  PARITY_ERROR;
  logic                  STOP_ERROR;
  logic                  busy;

  modport master (
    output RX_IN,
    output par_EN,
    output par_TYP,
    input  RXDATA,
    input  VALID_RX,
    input  PARITY_ERROR,
    input  STOP_ERROR,
    input  busy
  );

  modport slave (
    input  RX_IN,
    input  par_EN,
    input  par_TYP,
    output RXDATA,
    output VALID_RX,
    output PARITY_ERROR,
    output STOP_ERROR,
    output busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Synchroniser, per-bit edge counter and mid-bit majority vote.
// bit_done marks the vote cycle, bit_end the last cycle of a bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic clear,
  output logic rx_s,
  output logic bit_val,
  output logic bit_done,
  output logic bit_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] MID_A = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] MID_B = CW'(PRESCALE/2);
  localparam logic [CW-1:0] MID_C = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          samp_a_q;
  logic          samp_b_q;
  logic [CW-1:0] edge_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      samp_a_q   <= 1'b0;
      samp_b_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      if (clear || edge_cnt_q == LAST)
        edge_cnt_q <= '0;
      else
        edge_cnt_q <= edge_cnt_q + 1'b1;
      if (edge_cnt_q == MID_A)
        samp_a_q <= sync2_q;
      if (edge_cnt_q == MID_B)
        samp_b_q <= sync2_q;
    end
  end

  // third vote is the live sample, so the decision lands on MID_C
  assign rx_s     = sync2_q;
  assign bit_val  = maj3(samp_a_q, samp_b_q, sync2_q);
  assign bit_done = !clear && (edge_cnt_q == MID_C);
  assign bit_end  = !clear && (edge_cnt_q == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receive path: frame FSM, shift register and error checks.
// Results are registered at the mid-stop-bit decision.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic CLK,
  input  logic RST,
  uart_rx_oversample_if.slave io
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  rx_state_t state_q;
  rx_state_t state_d;

  logic                  rx_s;
  logic                  bit_val;
  logic                  bit_done;
  logic                  bit_end;
  logic                  clear;
  logic                  entry;
  logic                  accept;
  logic                  finish;
  logic                  last_bit;
  logic                  par_err;
  logic                  armed_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] rxdata_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  serr_q;

  assign clear = (state_q == IDLE);

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (RST),
    .rx_in    (io.RX_IN),
    .clear    (clear),
    .rx_s     (rx_s),
    .bit_val  (bit_val),
    .bit_done (bit_done),
    .bit_end  (bit_end)
  );

  assign last_bit = (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign par_err  = par_en_q & (^shift_q ^ par_bit_q ^ par_typ_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // entry needs a falling edge, so a held break cannot re-trigger
  always_comb begin
    state_d = state_q;
    entry   = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = START;
          entry   = 1'b1;
        end
      end
      START: begin
        if (bit_done && bit_val) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
          accept  = 1'b1;
        end
      end
      DATA: begin
        if (bit_end && last_bit)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end)
          state_d = STOP;
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed_q   <= 1'b1;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit_q <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rxdata_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      armed_q <= rx_s;
      if (entry) begin
        par_en_q  <= io.par_EN;
        par_typ_q <= io.par_TYP;
        bit_cnt_q <= '0;
      end
      // flags survive a rejected glitch; clear once start is confirmed
      if (accept) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        serr_q  <= 1'b0;
      end
      if (state_q == DATA && bit_done)
        shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
      if (state_q == DATA && bit_end)
        bit_cnt_q <= bit_cnt_q + 1'b1;
      if (state_q == PARITY && bit_done)
        par_bit_q <= bit_val;
      if (finish) begin
        serr_q <= !bit_val;
        perr_q <= par_err;
        if (bit_val && !par_err) begin
          rxdata_q <= shift_q;
          valid_q  <= 1'b1;
        end else begin
          valid_q  <= 1'b0;
        end
      end
    end
  end

  assign io.RXDATA       = rxdata_q;
  assign io.VALID_RX     = valid_q;
  assign io.PARITY_ERROR = perr_q;
  assign io.STOP_ERROR   = serr_q;
  assign io.busy         = (state_q != IDLE);

endmodule
